dmem_responder: RTL and testbench

Data-memory responder for the in-order RV32I pipeline. It is the target end of the MEM stage load/store request channel: it accepts one request at a time, models a fixed access latency, and performs little-endian byte/half/word stores. Loads return sign- or zero-extended data over a valid/ready response channel. It sits beside `toplevel` as the data-side memory and is exercised through the same clock/reset environment as the core.

---
 rtl/dmem_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-side memory responder for the in-order RV32I pipeline. It accepts one
// load/store request at a time and waits a fixed number of cycles. It then
// performs a little-endian byte/half/word access into a word-organised array
// and presents the result on a valid/ready response channel. Loads are sign-
// or zero-extended according to req_unsigned.
//
// Parameters
//   ADDR_W   word-address width; the array holds 2**ADDR_W 32-bit words
//   LATENCY  cycles from request accept to resp_valid (1..15)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset of control/output state
//   req_valid     request present
//   req_ready     responder can accept a request (high only in IDLE)
//   req_we        1 = store, 0 = load
//   req_addr      byte address; bits above ADDR_W+1 are ignored (wrap)
//   req_size      0 = byte, 1 = half, 2/3 = word
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_wdata     right-aligned store data
//   resp_valid    response present
//   resp_ready    requester takes the response
//   resp_rdata    load result, 0 for stores and trapped accesses
//   resp_err      misaligned-access flag
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses return
//                          resp_err=1 with no array write. When undefined,
//                          the low address bits are forced to alignment and
//                          resp_err is always 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t r_state;
  state_t w_nextState;

  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  logic              w_accept;
  logic              w_commit;
  logic              w_write;
  logic [ADDR_W-1:0] w_index;
  logic [1:0]        w_lane;
  logic              w_misalign;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_wdataLanes;
  logic [31:0]       w_word;
  logic [31:0]       w_shifted;
  logic [31:0]       w_loadData;
  logic              w_unused;

  // Address bits above the array are intentionally dropped so that accesses
  // wrap modulo the memory size.
  assign w_unused = ^req_addr[31:ADDR_W+2];

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_index  = r_addr[ADDR_W+1:2];

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // State register; an asynchronous reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one outstanding request, held in RESP until taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nextState = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Lane selection and alignment. Without the trap option the low address
  // bits are simply forced to the natural alignment of the access size.
  always_comb begin
    w_lane     = r_addr[1:0];
    w_misalign = 1'b0;
    case (r_size)
      2'd0: begin
        w_lane = r_addr[1:0];
      end
      2'd1: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misalign = r_addr[0];
`endif
        w_lane = {r_addr[1], 1'b0};
      end
      default: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misalign = |r_addr[1:0];
`endif
        w_lane = 2'b00;
      end
    endcase
  end

  // Store byte enables, with the right-aligned store data replicated across
  // the word so that every enabled lane sees the correct byte.
  always_comb begin
    w_byteEn     = 4'b0000;
    w_wdataLanes = r_wdata;
    case (r_size)
      2'd0: begin
        w_byteEn     = 4'b0001 << w_lane;
        w_wdataLanes = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_byteEn     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdataLanes = {2{r_wdata[15:0]}};
      end
      default: begin
        w_byteEn     = 4'b1111;
        w_wdataLanes = r_wdata;
      end
    endcase
  end

  // Load path: shift the addressed lane down to bit 0, then extend.
  assign w_word    = r_mem[w_index];
  assign w_shifted = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_loadData = w_word;
    case (r_size)
      2'd0: begin
        w_loadData = r_uns ? {24'd0, w_shifted[7:0]}
                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      2'd1: begin
        w_loadData = r_uns ? {16'd0, w_shifted[15:0]}
                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        w_loadData = w_word;
      end
    endcase
  end

  assign w_write = w_commit && r_we && !w_misalign;

  // The array itself has no reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) begin
          r_mem[w_index][8*i +: 8] <= w_wdataLanes[8*i +: 8];
        end
      end
    end
  end

  // Request capture, latency countdown and the registered response. The
  // response registers are written only on the commit edge, so they hold
  // steady for as long as the requester applies backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= LAT_INIT;
        r_we    <= req_we;
        r_addr  <= req_addr[ADDR_W+1:0];
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_wdata <= req_wdata;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (r_we || w_misalign) ? 32'd0 : w_loadData;
        r_err   <= w_misalign;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed self-checking bench for dmem_responder (ADDR_W=10, LATENCY=2).
// It covers reset values, a reset while a store is in flight, byte and half
// lanes with both extensions, response latency under backpressure, address
// wrap-around and misaligned word stores under both build options.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .ADDR_W (10),
    .LATENCY(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full request/response transaction with resp_ready held high.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    resp_ready   = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("reqReadyTimeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("respValidTimeout", {31'd0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    resp_ready   = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstRespRdata", resp_rdata, 32'd0);
    checkOutput("rstRespErr", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;

    // Reset while a store is in flight must not write the array
    applyStimulus(1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678, rd, er);
    checkOutput("storeRdataZero", rd, 32'd0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_size  = 2'd2;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("busyReqReady", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midRstRespValid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postRstReqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("postRstRespValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("postRstRespErr", {31'd0, resp_err}, 32'd0);
    applyStimulus(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("rstDiscardWord40", rd, 32'h12345678);

    // Byte store and byte loads
    applyStimulus(1'b1, 32'h100, 2'd2, 1'b0, 32'h11223344, rd, er);
    applyStimulus(1'b1, 32'h102, 2'd0, 1'b0, 32'h00000080, rd, er);
    applyStimulus(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("byteStoreWord", rd, 32'h11803344);
    applyStimulus(1'b0, 32'h102, 2'd0, 1'b0, 32'd0, rd, er);
    checkOutput("byteLoadSigned", rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 32'h102, 2'd0, 1'b1, 32'd0, rd, er);
    checkOutput("byteLoadUnsigned", rd, 32'h00000080);
    applyStimulus(1'b0, 32'h101, 2'd0, 1'b1, 32'd0, rd, er);
    checkOutput("byteLoadLane1", rd, 32'h00000033);

    // Half store and half loads
    applyStimulus(1'b1, 32'h204, 2'd2, 1'b0, 32'h55667788, rd, er);
    applyStimulus(1'b1, 32'h206, 2'd1, 1'b0, 32'h0000BEEF, rd, er);
    applyStimulus(1'b0, 32'h206, 2'd1, 1'b0, 32'd0, rd, er);
    checkOutput("halfLoadSigned", rd, 32'hFFFFBEEF);
    applyStimulus(1'b0, 32'h206, 2'd1, 1'b1, 32'd0, rd, er);
    checkOutput("halfLoadUnsigned", rd, 32'h0000BEEF);
    applyStimulus(1'b0, 32'h204, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("halfStoreWord", rd, 32'hBEEF7788);
    applyStimulus(1'b0, 32'h204, 2'd1, 1'b0, 32'd0, rd, er);
    checkOutput("halfLoadLowPos", rd, 32'h00007788);

    // Latency and backpressure
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = 32'h100;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    resp_ready   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("latEdgeN", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latEdgeN1", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latEdgeN2", {31'd0, resp_valid}, 32'd1);
    checkOutput("latRdata", resp_rdata, 32'h11803344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpRespValid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bpRdata", resp_rdata, 32'h11803344);
      checkOutput("bpReqReady", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpReleaseReqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("bpReleaseRespValid", {31'd0, resp_valid}, 32'd0);

    // Address wrap modulo 4 KiB
    applyStimulus(1'b1, 32'h1000, 2'd2, 1'b0, 32'h0BADF00D, rd, er);
    applyStimulus(1'b0, 32'h0000, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("addrWrap", rd, 32'h0BADF00D);

    // Misaligned word store
    applyStimulus(1'b1, 32'h300, 2'd2, 1'b0, 32'hA5A5A5A5, rd, er);
    applyStimulus(1'b1, 32'h301, 2'd2, 1'b0, 32'hCAFEF00D, rd, er);
    checkOutput("misalignRdata", rd, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkOutput("misalignErr", {31'd0, er}, 32'd1);
    applyStimulus(1'b0, 32'h300, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("misalignWord300", rd, 32'hA5A5A5A5);
`else
    checkOutput("misalignErr", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 32'h300, 2'd2, 1'b0, 32'd0, rd, er);
    checkOutput("misalignWord300", rd, 32'hCAFEF00D);
`endif
    checkOutput("alignedLoadErr", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
